ps2_host_tx: RTL and testbench
==============================

Name: ps2_host_tx

Overview:
- Host-to-device PS/2 transmitter. It is the send side for the existing keyboard receiver (ps2), on the same ps2Clk/ps2Data open-collector pair.
- Sends one command byte per request to the keyboard, e.g. 0xED set-LEDs (caps/kana state) or 0xFF reset.
- Performs inhibit, request-to-send, device-clocked bit shifting with odd parity, and ACK check.
- Runs in the cpuClock (25 MHz) domain. The top level turns the *_oe outputs into the tri-state drive.

Parameters:
- INHIBIT_CYC, 2500: cycles ps2_clk is held low before request (100 us at 25 MHz).
- REQ_CYC, 16: cycles both lines are held low before ps2_clk is released.
- START_TIMEOUT, 375000: max cycles from clock release to the first device falling edge (15 ms).
- EDGE_TIMEOUT, 50000: max cycles between consecutive device falling edges, and for the final idle wait (2 ms).

Ports:
- clk, input, 1: system clock (cpuClock).
- reset_n, input, 1: asynchronous active-low reset.
- ps2_clk_in, input, 1: raw PS/2 clock pin level, asynchronous.
- ps2_data_in, input, 1: raw PS/2 data pin level, asynchronous.
- ps2_clk_oe, output, 1: 1 = drive ps2Clk low, 0 = release.
- ps2_data_oe, output, 1: 1 = drive ps2Data low, 0 = release.
- tx_data, input, 8: command byte, sampled when tx_valid is accepted.
- tx_valid, input, 1: send request, single-cycle or level.
- busy, output, 1: high from acceptance until done/error. Also used to gate the receiver.
- done, output, 1: one-cycle pulse when the frame completes and the device ACKed.
- ack_err, output, 1: one-cycle pulse when the frame completes with data high at the ACK edge.
- timeout, output, 1: one-cycle pulse when a timeout aborts the frame.

Behaviour:
- Reset (asynchronous)
  - All outputs 0, state IDLE, shift/count registers cleared.
  - Both lines are released immediately, including when reset hits mid-frame.
- Inputs
  - Each pin input passes through a 2-FF synchronizer plus one history FF.
  - fall = previous synchronized sample 1 and current synchronized sample 0 on ps2_clk.
- IDLE
  - Both oe = 0, busy = 0.
  - tx_valid = 1 latches tx_data, computes parity = ~^tx_data (odd), sets busy the next cycle and goes to INHIBIT.
  - tx_valid is ignored in every other state.
- INHIBIT
  - ps2_clk_oe = 1, ps2_data_oe = 0 for exactly INHIBIT_CYC cycles, then REQ.
- REQ
  - ps2_clk_oe = 1, ps2_data_oe = 1 (start bit 0) for REQ_CYC cycles.
  - Then go to SHIFT with ps2_clk_oe = 0, bit count n = 0, timer cleared.
- SHIFT: on each fall, n increments and the host sets data:
  - n = 1..8: ps2_data_oe = ~tx_data[n-1] (LSB first).
  - n = 9: ps2_data_oe = ~parity.
  - n = 10: ps2_data_oe = 0 (stop bit, line released). Go to ACK.
- Timeouts in SHIFT
  - Timer counts every cycle and clears on each fall.
  - Limit is START_TIMEOUT while n = 0 and EDGE_TIMEOUT after that.
  - When the limit is reached: release both lines, pulse timeout, go to IDLE.
- ACK
  - On the next fall (11th), sample synchronized data. 0 = ack ok, 1 = nack.
  - Go to WAIT_IDLE.
  - The EDGE_TIMEOUT rule applies here too.
- WAIT_IDLE
  - Wait until synchronized clk and data are both 1.
  - Then pulse done (ack ok) or ack_err (nack), clear busy and go to IDLE.
  - Reaching EDGE_TIMEOUT here gives a timeout pulse instead.
- Pulse and busy rules
  - Exactly one of done, ack_err or timeout pulses per accepted request.
  - busy falls in the same cycle as that pulse.
- Counters
  - Timer is wide enough for max(START_TIMEOUT, EDGE_TIMEOUT), 19 bits at the defaults.
  - n is 4 bits.
  - No wrap-around is possible; all compares are ">= limit".
- Device clock edges
  - Falls seen in IDLE, INHIBIT or REQ are ignored.
  - During INHIBIT/REQ the host itself drives clk low, so no fall is detected from its own drive.

Test Plan:
1. Defaults reduced (INHIBIT_CYC = 20, REQ_CYC = 4, timeouts = 2000), device model clocking at 1 µs half-period with ACK; send 0xED -> data bits 1,0,1,1,0,1,1,1 on falls 1–8, parity bit 1, stop 1, done pulses once, busy low after, ack_err/timeout stay 0.
2. Send 0x01 with model ACKing -> parity bit 0 at fall 9, done pulse.
3. Model clocks 11 edges but leaves data high at ACK -> ack_err single pulse, done 0, both oe 0 at end.
4. Model never clocks after release -> timeout pulse exactly START_TIMEOUT cycles after entering SHIFT, both lines released, busy 0.
5. Assert reset_n = 0 during bit 4 of 0xFF -> ps2_clk_oe = ps2_data_oe = 0 in the same cycle (asynchronous), busy 0. After release, a new 0xF4 send completes with done.
6. Pulse tx_valid with 0xAA while busy sending 0x55 -> only 0x55 is transmitted, one done pulse; check INHIBIT length = 20 cycles with ps2_data_oe = 0.

Source files
------------

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: clock inhibit, request-to-send, then
// shifts one command byte (LSB first, odd parity, stop) on the device's
// clock and checks the device ACK. The *_oe outputs pull the open-collector
// lines low when set.
//
// state     | meaning
// ----------|----------------------------------------------------------
// IDLE      | lines released, waiting for tx_valid
// INHIBIT   | host holds ps2_clk low for INHIBIT_CYC cycles
// REQ       | host holds clk and data low (start bit) for REQ_CYC cycles
// SHIFT     | clk released; data bits, parity, stop driven on device falls
// ACK       | waiting for the 11th fall to sample the device ACK
// WAIT_IDLE | waiting for both lines high before reporting the result
module ps2_host_tx #(
  parameter int INHIBIT_CYC   = 2500,
  parameter int REQ_CYC       = 16,
  parameter int START_TIMEOUT = 375000,
  parameter int EDGE_TIMEOUT  = 50000
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       ps2_clk_in,
  input  logic       ps2_data_in,
  output logic       ps2_clk_oe,
  output logic       ps2_data_oe,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       busy,
  output logic       done,
  output logic       ack_err,
  output logic       timeout
);

  localparam int TO_MAX = (START_TIMEOUT > EDGE_TIMEOUT) ? START_TIMEOUT : EDGE_TIMEOUT;
  localparam int SQ_MAX = (INHIBIT_CYC > REQ_CYC) ? INHIBIT_CYC : REQ_CYC;
  localparam int T_MAX  = (TO_MAX > SQ_MAX) ? TO_MAX : SQ_MAX;
  localparam int TW     = $clog2(T_MAX + 1);

  // The "last" values are the final count of each interval, so an interval
  // of N cycles spans timer values 0..N-1.
  localparam logic [TW-1:0] INHIBIT_LAST = TW'(INHIBIT_CYC - 1);
  localparam logic [TW-1:0] REQ_LAST     = TW'(REQ_CYC - 1);
  localparam logic [TW-1:0] START_LAST   = TW'(START_TIMEOUT - 1);
  localparam logic [TW-1:0] EDGE_LAST    = TW'(EDGE_TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_INHIBIT, S_REQ, S_SHIFT, S_ACK, S_WAIT_IDLE
  } state_t;

  state_t        state, state_next;
  logic [2:0]    clk_pipe, data_pipe;
  logic [7:0]    data_reg;
  logic          parity;
  logic [TW-1:0] timer;
  logic [3:0]    n;
  logic [3:0]    n_inc;
  logic          data_oe_r;
  logic          ack_bad;
  logic          done_r, ack_err_r, timeout_r;
  logic          clk_sync, clk_prev, data_sync, data_prev;
  logic          fall, line_idle, expired;
  logic [TW-1:0] limit;

  assign clk_sync  = clk_pipe[1];
  assign clk_prev  = clk_pipe[2];
  assign data_sync = data_pipe[1];
  assign data_prev = data_pipe[2];
  assign fall      = clk_prev & ~clk_sync;
  // Data must read high on two consecutive samples before the bus is idle.
  assign line_idle = clk_sync & data_sync & data_prev;
  assign limit     = (state == S_SHIFT && n == 4'd0) ? START_LAST : EDGE_LAST;
  assign expired   = (timer >= limit);
  assign n_inc     = n + 4'd1;

  // Two-stage synchronizer plus one history stage per pin; idle-high reset
  // keeps a spurious fall from appearing right after reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      clk_pipe  <= 3'b111;
      data_pipe <= 3'b111;
    end else begin
      clk_pipe  <= {clk_pipe[1:0], ps2_clk_in};
      data_pipe <= {data_pipe[1:0], ps2_data_in};
    end
  end

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= S_IDLE;
    else          state <= state_next;
  end

  // Next-state logic.
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:      if (tx_valid) state_next = S_INHIBIT;
      S_INHIBIT:   if (timer >= INHIBIT_LAST) state_next = S_REQ;
      S_REQ:       if (timer >= REQ_LAST) state_next = S_SHIFT;
      S_SHIFT: begin
        if (fall) begin
          if (n_inc == 4'd10) state_next = S_ACK;
        end else if (expired) begin
          state_next = S_IDLE;
        end
      end
      S_ACK: begin
        if (fall)         state_next = S_WAIT_IDLE;
        else if (expired) state_next = S_IDLE;
      end
      S_WAIT_IDLE:   if (line_idle || expired) state_next = S_IDLE;
      default:       state_next = S_IDLE;
    endcase
  end

  // Datapath: byte latch, bit counter, shared interval/timeout timer, result pulses.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      data_reg  <= '0;
      parity    <= 1'b0;
      timer     <= '0;
      n         <= '0;
      data_oe_r <= 1'b0;
      ack_bad   <= 1'b0;
      done_r    <= 1'b0;
      ack_err_r <= 1'b0;
      timeout_r <= 1'b0;
    end else begin
      done_r    <= 1'b0;
      ack_err_r <= 1'b0;
      timeout_r <= 1'b0;
      case (state)
        S_IDLE: begin
          timer     <= '0;
          n         <= '0;
          data_oe_r <= 1'b0;
          if (tx_valid) begin
            data_reg <= tx_data;
            parity   <= ~^tx_data;
          end
        end
        S_INHIBIT: timer <= (timer >= INHIBIT_LAST) ? '0 : timer + TW'(1);
        S_REQ: begin
          if (timer >= REQ_LAST) begin
            timer     <= '0;
            n         <= '0;
            data_oe_r <= 1'b1;   // start bit keeps data low after clk release
          end else begin
            timer <= timer + TW'(1);
          end
        end
        S_SHIFT: begin
          if (fall) begin
            timer <= '0;
            n     <= n_inc;
            if (n_inc <= 4'd8)       data_oe_r <= ~data_reg[n[2:0]];
            else if (n_inc == 4'd9)  data_oe_r <= ~parity;
            else                     data_oe_r <= 1'b0;
          end else if (expired) begin
            timeout_r <= 1'b1;
            data_oe_r <= 1'b0;
          end else begin
            timer <= timer + TW'(1);
          end
        end
        S_ACK: begin
          if (fall) begin
            ack_bad <= data_sync;
            timer   <= '0;
          end else if (expired) begin
            timeout_r <= 1'b1;
          end else begin
            timer <= timer + TW'(1);
          end
        end
        S_WAIT_IDLE: begin
          if (line_idle) begin
            done_r    <= ~ack_bad;
            ack_err_r <= ack_bad;
          end else if (expired) begin
            timeout_r <= 1'b1;
          end else begin
            timer <= timer + TW'(1);
          end
        end
        default: timer <= '0;
      endcase
    end
  end

  // Outputs decoded from state so reset releases both lines without a clock.
  always_comb begin
    busy        = (state != S_IDLE);
    ps2_clk_oe  = (state == S_INHIBIT) || (state == S_REQ);
    ps2_data_oe = 1'b0;
    if (state == S_REQ)                           ps2_data_oe = 1'b1;
    else if (state == S_SHIFT || state == S_ACK)  ps2_data_oe = data_oe_r;
    done    = done_r;
    ack_err = ack_err_r;
    timeout = timeout_r;
  end

endmodule

// File: tb/tb_ps2_host_tx.sv
// Bench for ps2_host_tx with a behavioural PS/2 device on open-collector lines.
`timescale 1ns/1ps
module tb_ps2_host_tx;

  localparam int HALF = 1000;   // device clock half-period, ns
  localparam int TO   = 2000;

  logic       clk, reset_n;
  logic       ps2_clk_in, ps2_data_in, ps2_clk_oe, ps2_data_oe;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       busy, done, ack_err, timeout;
  logic       dev_clk_low, dev_data_low;

  int n_checks, n_fail;
  int done_cnt, err_cnt, to_cnt, accept_cnt, pulse_bad;
  logic busy_q;

  typedef struct {
    logic [7:0] data;
    bit         do_ack;
    logic [9:0] exp_bits;
    int         exp_done;
    int         exp_err;
  } vec_t;

  vec_t vecs[4];

  ps2_host_tx #(
    .INHIBIT_CYC(20), .REQ_CYC(4), .START_TIMEOUT(TO), .EDGE_TIMEOUT(TO)
  ) dut (
    .clk(clk), .reset_n(reset_n),
    .ps2_clk_in(ps2_clk_in), .ps2_data_in(ps2_data_in),
    .ps2_clk_oe(ps2_clk_oe), .ps2_data_oe(ps2_data_oe),
    .tx_data(tx_data), .tx_valid(tx_valid),
    .busy(busy), .done(done), .ack_err(ack_err), .timeout(timeout)
  );

  assign ps2_clk_in  = ~(ps2_clk_oe | dev_clk_low);
  assign ps2_data_in = ~(ps2_data_oe | dev_data_low);

  initial clk = 0;
  always #20 clk = ~clk;

  // Pulse monitor: counts result pulses and flags pulses not aligned with busy falling.
  always @(negedge clk) begin
    if (done)    done_cnt <= done_cnt + 1;
    if (ack_err) err_cnt  <= err_cnt + 1;
    if (timeout) to_cnt   <= to_cnt + 1;
    if ((done || ack_err || timeout) && (busy || !busy_q)) pulse_bad <= pulse_bad + 1;
    if ((32'(done) + 32'(ack_err) + 32'(timeout)) > 1) pulse_bad <= pulse_bad + 1;
    if (busy && !busy_q) accept_cnt <= accept_cnt + 1;
    busy_q <= busy;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic bound_fail(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s: wait bound expired", name);
  endtask

  task automatic wait_clk_oe(input logic lvl, input int limit, output bit ok);
    ok = 0;
    for (int i = 0; i < limit; i++) begin
      @(negedge clk);
      if (ps2_clk_oe === lvl) begin
        ok = 1;
        return;
      end
    end
  endtask

  task automatic send(input logic [7:0] b);
    @(negedge clk);
    tx_data  = b;
    tx_valid = 1;
    @(negedge clk);
    tx_valid = 0;
  endtask

  // One device clock pulse; samples the data line while the clock is high.
  task automatic dev_clock(output logic s);
    dev_clk_low = 1;
    #(HALF);
    dev_clk_low = 0;
    #(HALF/2);
    s = ps2_data_in;
    #(HALF/2);
  endtask

  task automatic wait_release(output bit ok);
    wait_clk_oe(1'b1, 200, ok);
    if (!ok) begin bound_fail("wait_clk_oe_high"); return; end
    wait_clk_oe(1'b0, 200, ok);
    if (!ok) begin bound_fail("wait_clk_oe_low"); return; end
    repeat (50) @(posedge clk);
    #7;
  endtask

  task automatic device_frame(input bit do_ack, output logic [9:0] bits, output logic st);
    bit ok;
    logic s;
    bits = '0;
    st   = 1'b1;
    wait_release(ok);
    if (!ok) return;
    st = ps2_data_in;
    for (int i = 0; i < 10; i++) begin
      dev_clock(s);
      bits[i] = s;
    end
    dev_data_low = do_ack;
    #(HALF);
    dev_clk_low = 1;
    #(HALF);
    dev_clk_low = 0;
    #(HALF);
    dev_data_low = 0;
  endtask

  task automatic wait_not_busy(input string name);
    int k;
    k = 0;
    while (busy && k < 500) begin
      @(negedge clk);
      k++;
    end
    if (busy) bound_fail(name);
    repeat (3) @(negedge clk);
  endtask

  task automatic end_checks(input vec_t v, input logic [9:0] bits, input logic st,
                            input int d0, input int e0, input int t0, input int p0);
    check("start_bit", 32'(st), 32'(0));
    check("frame_bits", 32'(bits), 32'(v.exp_bits));
    check("done_pulses", done_cnt - d0, v.exp_done);
    check("ack_err_pulses", err_cnt - e0, v.exp_err);
    check("timeout_pulses", to_cnt - t0, 0);
    check("pulse_busy_align", pulse_bad - p0, 0);
    check("end_state", {29'd0, busy, ps2_clk_oe, ps2_data_oe}, 32'd0);
  endtask

  task automatic run_vec(input vec_t v);
    int d0, e0, t0, p0;
    logic [9:0] bits;
    logic st;
    d0 = done_cnt; e0 = err_cnt; t0 = to_cnt; p0 = pulse_bad;
    send(v.data);
    device_frame(v.do_ack, bits, st);
    wait_not_busy("frame_end");
    end_checks(v, bits, st, d0, e0, t0, p0);
  endtask

  initial begin
    int d0, e0, t0, a0, k, inh;
    bit ok;
    logic s, st;
    logic [9:0] bits;
    vec_t v;

    n_checks = 0; n_fail = 0;
    done_cnt = 0; err_cnt = 0; to_cnt = 0; accept_cnt = 0; pulse_bad = 0;
    busy_q = 0;
    reset_n = 0; tx_valid = 0; tx_data = 0;
    dev_clk_low = 0; dev_data_low = 0;

    vecs[0] = '{8'hED, 1'b1, 10'h3ED, 1, 0};
    vecs[1] = '{8'h01, 1'b1, 10'h201, 1, 0};
    vecs[2] = '{8'h00, 1'b0, 10'h300, 0, 1};
    vecs[3] = '{8'h3A, 1'b1, 10'h33A, 1, 0};

    repeat (4) @(negedge clk);
    check("reset_outputs", {26'd0, busy, done, ack_err, timeout, ps2_clk_oe, ps2_data_oe}, 32'd0);
    reset_n = 1;
    repeat (4) @(negedge clk);

    // Table-driven frames
    for (int i = 0; i < 4; i++) run_vec(vecs[i]);

    // No device clock after release: start timeout
    d0 = done_cnt; e0 = err_cnt; t0 = to_cnt;
    send(8'h12);
    wait_clk_oe(1'b1, 200, ok);
    if (!ok) bound_fail("to_wait_high");
    wait_clk_oe(1'b0, 200, ok);
    if (!ok) bound_fail("to_wait_low");
    k = 0;
    while (!timeout && k < 3000) begin
      @(negedge clk);
      k++;
    end
    check("timeout_latency", k, TO);
    check("timeout_release", {30'd0, ps2_clk_oe, ps2_data_oe}, 32'd0);
    check("timeout_busy", 32'(busy), 32'(0));
    repeat (3) @(negedge clk);
    check("timeout_pulses", to_cnt - t0, 1);
    check("timeout_no_done", (done_cnt - d0) + (err_cnt - e0), 0);

    // Asynchronous reset during INHIBIT (host driving clk low)
    send(8'hFF);
    repeat (5) @(negedge clk);
    check("inhibit_clk_oe", 32'(ps2_clk_oe), 32'(1));
    #5 reset_n = 0;
    #1;
    check("async_reset_inhibit", {30'd0, busy, ps2_clk_oe}, 32'd0);
    @(negedge clk);
    reset_n = 1;
    repeat (4) @(negedge clk);

    // Asynchronous reset during data bit 4 of 0xFF
    send(8'hFF);
    wait_release(ok);
    if (ok) begin
      for (int i = 0; i < 4; i++) dev_clock(s);
      dev_clk_low = 1;
      #(HALF/2);
      reset_n = 0;
      #1;
      check("async_reset_shift", {29'd0, busy, ps2_clk_oe, ps2_data_oe}, 32'd0);
      #(HALF/2);
      dev_clk_low = 0;
    end
    repeat (10) @(negedge clk);
    reset_n = 1;
    repeat (4) @(negedge clk);
    v = '{8'hF4, 1'b1, 10'h2F4, 1, 0};
    run_vec(v);

    // tx_valid while busy is ignored; INHIBIT length with data released
    d0 = done_cnt; e0 = err_cnt; t0 = to_cnt; a0 = accept_cnt;
    k = pulse_bad;
    @(negedge clk);
    tx_data = 8'h55;
    tx_valid = 1;
    @(negedge clk);
    tx_valid = 0;
    inh = 0;
    while (ps2_clk_oe && !ps2_data_oe && inh < 100) begin
      inh++;
      if (inh == 5) begin
        tx_data  = 8'hAA;
        tx_valid = 1;
      end else begin
        tx_valid = 0;
      end
      @(negedge clk);
    end
    tx_valid = 0;
    check("inhibit_length", inh, 20);
    check("req_both_low", {30'd0, ps2_clk_oe, ps2_data_oe}, 32'd3);
    device_frame(1'b1, bits, st);
    wait_not_busy("busy_frame_end");
    v = '{8'h55, 1'b1, 10'h355, 1, 0};
    end_checks(v, bits, st, d0, e0, t0, k);
    repeat (200) @(negedge clk);
    check("single_accept", accept_cnt - a0, 1);
    check("idle_after", {29'd0, busy, ps2_clk_oe, ps2_data_oe}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
